scariv_done_rpt_arbiter: RTL

// - Receiving end of the scheduler-entry done-report handshake (done_rpt_t valid / i_done_accept).
// - Collects done reports from NUM_ENTRIES scheduler entries, grants one per cycle by round-robin,

---
 rtl/scariv_done_rpt_arbiter_if.sv | 64 ++++++
 rtl/scariv_done_rpt_arbiter.sv | 95 +++++++++
 2 files changed

// File: rtl/scariv_done_rpt_arbiter_if.sv
// Done-report payload types and the entry-array / ROB handshake bundle
// around one scheduler's done-report arbiter.
package scariv_done_rpt_pkg;

   localparam int unsigned CMT_ID_W  = 6;
   localparam int unsigned DISP_SIZE = 4;

   typedef struct packed {
      logic                 valid;
      logic [CMT_ID_W-1:0]  cmt_id;
      logic [DISP_SIZE-1:0] grp_id;
      logic                 except_valid;
      logic [3:0]           except_type;
      logic                 fflags_update_valid;
      logic [4:0]           fflags;
   } done_rpt_t;

   typedef struct packed {
      logic                 commit;
      logic                 flush_valid;
      logic [CMT_ID_W-1:0]  cmt_id;
      logic [DISP_SIZE-1:0] grp_id;
   } commit_blk_t;

   // Everything in flight dies on a commit flush except the group slots that commit now.
   function automatic logic is_commit_flush_target(input logic [CMT_ID_W-1:0]  cmt_id,
                                                   input logic [DISP_SIZE-1:0] grp_id,
                                                   input commit_blk_t          commit);
      return commit.commit & commit.flush_valid &
             !((cmt_id == commit.cmt_id) & (|(grp_id & commit.grp_id)));
   endfunction

endpackage

interface scariv_done_rpt_if
   import scariv_done_rpt_pkg::*;
#(
   parameter int unsigned NUM_ENTRIES = 8
);
   done_rpt_t              done_rpt [NUM_ENTRIES];
   logic [NUM_ENTRIES-1:0] done_accept;
   commit_blk_t            commit;
   done_rpt_t              rob_done;
   logic                   rob_ready;
   logic                   busy;

   modport master (
      output done_rpt,
      input  done_accept,
      output commit,
      input  rob_done,
      output rob_ready,
      input  busy
   );

   modport slave (
      input  done_rpt,
      output done_accept,
      input  commit,
      output rob_done,
      input  rob_ready,
      output busy
   );
endinterface

// File: rtl/scariv_done_rpt_arbiter.sv
// Round-robin pick of one scheduler-entry done report per cycle into a
// single output register toward the ROB; the register is killed by commit flush.
module scariv_done_rpt_arbiter
   import scariv_done_rpt_pkg::*;
#(
   parameter int unsigned NUM_ENTRIES = 8
)(
   input logic              i_clk,
   input logic              i_reset_n,
   scariv_done_rpt_if.slave bus
);

   localparam int unsigned PW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

   done_rpt_t              r_out_q, r_out_d;
   logic [PW-1:0]          r_ptr_q, r_ptr_d;

   logic [NUM_ENTRIES-1:0] w_req;
   logic [NUM_ENTRIES-1:0] w_accept;
   logic                   w_out_flush;
   logic                   w_free;
   logic                   w_found;
   logic [PW-1:0]          w_win;
   logic                   w_grant;

   always_comb begin : req_vec
      w_req = '0;
      for (int unsigned k = 0; k < NUM_ENTRIES; k++) begin
         w_req[k] = bus.done_rpt[k].valid;
      end
   end

   assign w_out_flush = is_commit_flush_target(r_out_q.cmt_id, r_out_q.grp_id, bus.commit)
                        & r_out_q.valid;
   assign w_free      = !r_out_q.valid | bus.rob_ready | w_out_flush;

   // First requester at or after r_ptr, wrapping modulo NUM_ENTRIES.
   always_comb begin : rr_pick
      int unsigned idx;
      idx     = 0;
      w_found = 1'b0;
      w_win   = '0;
      for (int unsigned off = 0; off < NUM_ENTRIES; off++) begin
         idx = 32'(r_ptr_q) + off;
         if (idx >= NUM_ENTRIES) idx = idx - NUM_ENTRIES;
         if (!w_found && w_req[PW'(idx)]) begin
            w_found = 1'b1;
            w_win   = PW'(idx);
         end
      end
   end

   // Accept never looks at a previous accept, so the entry handshake stays loop-free.
   always_comb begin : accept_gen
      w_accept = '0;
      if (i_reset_n && w_free && w_found) w_accept[w_win] = 1'b1;
   end

   assign w_grant = |w_accept;

   always_comb begin : next_state
      r_out_d = r_out_q;
      r_ptr_d = r_ptr_q;
      if (w_grant) begin
         r_out_d = bus.done_rpt[w_win];
         r_ptr_d = (w_win == PW'(NUM_ENTRIES - 1)) ? '0 : PW'(w_win + 1'b1);
      end else if (r_out_q.valid && (bus.rob_ready || w_out_flush)) begin
         r_out_d.valid = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_out_q <= '0;
         r_ptr_q <= '0;
      end else begin
         r_out_q <= r_out_d;
         r_ptr_q <= r_ptr_d;
      end
   end

   assign bus.done_accept = w_accept;
   assign bus.rob_done    = r_out_q;
   assign bus.busy        = r_out_q.valid;

`ifndef SYNTHESIS
   a_accept_onehot : assert property (@(posedge i_clk) disable iff (!i_reset_n)
      $onehot0(w_accept));
   a_accept_has_req : assert property (@(posedge i_clk) disable iff (!i_reset_n)
      ((w_accept & ~w_req) == '0));
   a_hold_stable : assert property (@(posedge i_clk) disable iff (!i_reset_n)
      (r_out_q.valid && !bus.rob_ready && !w_out_flush) |=> $stable(r_out_q));
`endif

endmodule
